mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single backing-memory port between the fetch requester (I) and the d_cache requester (D).
//  Sits between the pipeline's fetch/mem stages and memory.
//  Serialises one transaction at a time: capture, issue, await response, return it to the owner.
// PARAMETERS
//  MAX_D_STREAK  4   consecutive D grants allowed while I is pending before I is forced (fixed-priority mode only)
// PORTS
//  clk            in   1   clock
//  n_rst          in   1   synchronous, active-low reset
//  i_req_valid    in   1   fetch request
//  i_req_addr     in   16  fetch address
//  i_req_ready    out  1   fetch request accepted this cycle
//  i_resp_valid   out  1   one-cycle pulse, fetch data valid
//  i_resp_data    out  16  fetch read data
//  d_req_valid    in   1   data request
//  d_req_addr     in   16  data address
//  d_req_op       in   MemOp  nand_cpu_pkg::MemOp; read or write
//  d_req_wdata    in   16  write data
//  d_req_ready    out  1   data request accepted this cycle
//  d_resp_valid   out  1   one-cycle pulse, data op complete
//  d_resp_data    out  16  read data; 16'h0000 for writes
//  mem_req_valid  out  1   request to memory
//  mem_req_ready  in   1   memory accepts request
//  mem_addr       out  16  memory address
//  mem_we         out  1   1 = write
//  mem_wdata      out  16  memory write data
//  mem_resp_valid in   1   memory response / write ack
//  mem_rdata      in   16  memory read data
// BEHAVIOUR
//  Reset: state=IDLE; all *_ready, *_resp_valid and mem_req_valid = 0.
//   Data outputs, owner, streak and last_grant = 0.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//  IDLE
//   - If exactly one requester is valid, it is granted.
//   - Its *_req_ready is asserted combinationally; the request is captured on the edge (cycle T).
//   - Next state ISSUE.
//  ISSUE
//   - mem_req_valid=1 with the captured addr/we/wdata, held stable until mem_req_ready.
//   - Then go to WAIT.
//  WAIT
//   - On mem_resp_valid at cycle R: owner's *_resp_valid=1 and *_resp_data are registered.
//   - Both are visible at R+1, and the FSM returns to IDLE at R+1.
//   - A new request can be accepted at R+1.
//  Minimum latency: accept at T, mem_req_valid at T+1, resp pulse at T+3 (1-cycle memory).
//  Arbitration when both requesters are valid in IDLE (default, fixed priority):
//   - D wins, and streak increments.
//   - If streak==MAX_D_STREAK, I wins instead and streak clears.
//   - Streak also clears on any grant with I not pending.
//  Unconditional rules:
//   - At most one of i_req_ready / d_req_ready is high per cycle.
//   - Neither is high outside IDLE.
//   - mem_resp_valid in IDLE or ISSUE is ignored; no response is generated.
//   - Requester inputs are don't-care while not ready; the captured copy is used.
//   - Reset mid-transaction aborts it: no resp pulse is produced; the memory response after reset is ignored.
// CONFIGURATION
//  MEM_PORT_ARB_RR_EN defined:
//   - Round-robin arbitration on conflict: the requester not in last_grant wins.
//   - last_grant updates on every grant; the streak counter and MAX_D_STREAK are unused.
//  MEM_PORT_ARB_RR_EN undefined: fixed D priority with the starvation guard above.
// STRUCTURE
//  nand_cpu_pkg additions:
//   - typedef enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT} ArbState
//   - typedef enum {REQ_I, REQ_D} ArbOwner
//  MemOp comes from nand_cpu_pkg. No sub-module; single flat module.
// TESTING
//  1. Reset: n_rst=0 for 2 cycles with both req_valid=1.
//     -> all ready/valid outputs 0; I accepted on the first cycle after release (D idle) or D (both valid).
//  2. Single read: D read 16'h0040, memory ready immediately, responds 16'hBEEF next cycle.
//     -> mem_addr=16'h0040, mem_we=0, d_resp_valid pulse with 16'hBEEF at T+3.
//  3. Write: D write 16'h1234 to 16'h0010, memory delays mem_req_ready 3 cycles.
//     -> request held stable for 4 cycles, mem_we=1; d_resp_data=16'h0000 on ack.
//  4. Starvation: I and D continuously valid, fixed mode.
//     -> grants D,D,D,D,I repeating; with MEM_PORT_ARB_RR_EN -> D,I,D,I.
//  5. Spurious response: mem_resp_valid pulsed in IDLE.
//     -> no resp pulse on either requester.
//  6. Reset during WAIT, then mem_resp_valid.
//     -> no resp pulse; FSM in IDLE; next request served normally.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: memory operation encoding and the memory-port arbiter
// state/owner encodings.
package nand_cpu_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } MemOp;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } ArbState;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } ArbOwner;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single backing-memory port between the fetch
// requester (I) and the data-cache requester (D). One transaction at a time:
// capture in IDLE, present to memory in ISSUE, await the response in WAIT.
// Build option MEM_PORT_ARB_RR_EN selects round-robin conflict resolution;
// without it D has fixed priority with a starvation guard of MAX_D_STREAK.
module mem_port_arbiter
    import nand_cpu_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_req_valid,
    input  logic [15:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_resp_valid,
    output logic [15:0] i_resp_data,
    input  logic        d_req_valid,
    input  logic [15:0] d_req_addr,
    input  MemOp        d_req_op,
    input  logic [15:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [15:0] d_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [15:0] mem_rdata
);

    ArbState     state_q, state_d;
    ArbOwner     owner_q, owner_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic        i_resp_valid_q, i_resp_valid_d;
    logic        d_resp_valid_q, d_resp_valid_d;
    logic [15:0] i_resp_data_q, i_resp_data_d;
    logic [15:0] d_resp_data_q, d_resp_data_d;
    logic        grant_i_s, grant_d_s;

`ifdef MEM_PORT_ARB_RR_EN
    ArbOwner     last_grant_q, last_grant_d;
`else
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] MAX_STREAK_C = STREAK_W'(MAX_D_STREAK);
    logic [STREAK_W-1:0] streak_q, streak_d;
`endif

    // Arbitration: pick at most one requester in IDLE; reset suppresses grants.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
        last_grant_d = last_grant_q;
`else
        streak_d = streak_q;
`endif
        if (n_rst && (state_q == ARB_IDLE)) begin
            if (i_req_valid && d_req_valid) begin
`ifdef MEM_PORT_ARB_RR_EN
                if (last_grant_q == REQ_D) begin
                    grant_i_s = 1'b1;
                end else begin
                    grant_d_s = 1'b1;
                end
`else
                if (streak_q == MAX_STREAK_C) begin
                    grant_i_s = 1'b1;
                    streak_d  = '0;
                end else begin
                    grant_d_s = 1'b1;
                    streak_d  = streak_q + STREAK_W'(1);
                end
`endif
            end else if (i_req_valid) begin
                grant_i_s = 1'b1;
`ifndef MEM_PORT_ARB_RR_EN
                streak_d  = '0;
`endif
            end else if (d_req_valid) begin
                grant_d_s = 1'b1;
`ifndef MEM_PORT_ARB_RR_EN
                streak_d  = '0;
`endif
            end else begin
                grant_i_s = 1'b0;
            end
`ifdef MEM_PORT_ARB_RR_EN
            if (grant_i_s) begin
                last_grant_d = REQ_I;
            end else if (grant_d_s) begin
                last_grant_d = REQ_D;
            end else begin
                last_grant_d = last_grant_q;
            end
`endif
        end else begin
            grant_d_s = 1'b0;
        end
    end

    // Transaction FSM: capture on grant, hold request until accepted, route response to owner.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        i_resp_valid_d = 1'b0;
        d_resp_valid_d = 1'b0;
        i_resp_data_d  = i_resp_data_q;
        d_resp_data_d  = d_resp_data_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant_i_s) begin
                    owner_d = REQ_I;
                    addr_d  = i_req_addr;
                    we_d    = 1'b0;
                    wdata_d = 16'h0000;
                    state_d = ARB_ISSUE;
                end else if (grant_d_s) begin
                    owner_d = REQ_D;
                    addr_d  = d_req_addr;
                    we_d    = (d_req_op == MEM_WRITE);
                    wdata_d = d_req_wdata;
                    state_d = ARB_ISSUE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = ARB_WAIT;
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = ARB_IDLE;
                    if (owner_q == REQ_D) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = we_q ? 16'h0000 : mem_rdata;
                    end else begin
                        i_resp_valid_d = 1'b1;
                        i_resp_data_d  = mem_rdata;
                    end
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q        <= ARB_IDLE;
            owner_q        <= REQ_I;
            addr_q         <= 16'h0000;
            we_q           <= 1'b0;
            wdata_q        <= 16'h0000;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            i_resp_data_q  <= 16'h0000;
            d_resp_data_q  <= 16'h0000;
`ifdef MEM_PORT_ARB_RR_EN
            last_grant_q   <= REQ_I;
`else
            streak_q       <= '0;
`endif
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            wdata_q        <= wdata_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
            i_resp_data_q  <= i_resp_data_d;
            d_resp_data_q  <= d_resp_data_d;
`ifdef MEM_PORT_ARB_RR_EN
            last_grant_q   <= last_grant_d;
`else
            streak_q       <= streak_d;
`endif
        end
    end

    assign i_req_ready   = grant_i_s;
    assign d_req_ready   = grant_d_s;
    assign i_resp_valid  = i_resp_valid_q;
    assign i_resp_data   = i_resp_data_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_data   = d_resp_data_q;
    assign mem_req_valid = (state_q == ARB_ISSUE);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions,
// then hand-written sequences for reset, starvation, back-to-back,
// spurious responses and reset during WAIT. Honours MEM_PORT_ARB_RR_EN.
module tb_mem_port_arbiter;
    import nand_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [15:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid;
    logic [15:0] d_req_addr, d_req_wdata, d_resp_data;
    MemOp        d_req_op;
    logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .n_rst(n_rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_op(d_req_op),
        .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct { logic is_d; logic [15:0] data; int lat; int acc_cyc; } resp_t;
    typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; } memreq_t;
    typedef struct { logic is_d; MemOp op; logic [15:0] addr; logic [15:0] wdata; int mdly; logic [15:0] exp; } vec_t;

    resp_t       exp_q[$];
    memreq_t     mreq_q[$];
    logic [15:0] mem_a [logic [15:0]];
    int nvec = 0, nfail = 0, cyc = 0, last_resp_cyc = -1, last_hold = 0;
    int mem_delay = 0, resp_delay = 0;
    bit spur = 1'b0, mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    // Memory model: programmable accept delay and response delay, sparse storage.
    initial begin
        int wcnt, rcnt;
        bit pend;
        logic [15:0] prd;
        wcnt = 0; rcnt = 0; pend = 1'b0; prd = 16'h0000;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 16'h0000;
        mem_a[16'h0040] = 16'hBEEF;
        forever begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (pend) begin
                if (rcnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = prd;
                    pend           = 1'b0;
                end else begin
                    rcnt--;
                end
            end
            if (spur) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 16'hDEAD;
            end
            if (mem_req_valid === 1'b1) begin
                if (mreq_q.size() == 0) begin
                    nvec++; nfail++;
                    $display("FAIL mem_unexpected_req: got addr %h, required no request", mem_addr);
                end else if (mem_addr !== mreq_q[0].addr || mem_we !== mreq_q[0].we ||
                             (mreq_q[0].we && mem_wdata !== mreq_q[0].wdata)) begin
                    nfail++;
                    $display("FAIL mem_req_stable: got %h/%b/%h, required %h/%b/%h",
                             mem_addr, mem_we, mem_wdata, mreq_q[0].addr, mreq_q[0].we, mreq_q[0].wdata);
                end
                if (wcnt == mem_delay) begin
                    mem_req_ready = 1'b1;
                    last_hold     = wcnt + 1;
                    if (mreq_q.size() != 0) begin
                        chk("mem_addr", mem_addr, mreq_q[0].addr);
                        chk("mem_we", mem_we, mreq_q[0].we);
                        if (mreq_q[0].we) chk("mem_wdata", mem_wdata, mreq_q[0].wdata);
                        void'(mreq_q.pop_front());
                    end
                    if (mem_we) begin
                        mem_a[mem_addr] = mem_wdata;
                        prd = 16'hFACE;
                    end else begin
                        prd = mem_a.exists(mem_addr) ? mem_a[mem_addr] : (mem_addr ^ 16'hC3C3);
                    end
                    pend = 1'b1;
                    rcnt = resp_delay;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (i_req_ready === 1'b1 && d_req_ready === 1'b1) begin
                    nvec++; nfail++;
                    $display("FAIL ready_exclusive: got both ready, required at most one");
                end
                if (i_resp_valid === 1'b1 || d_resp_valid === 1'b1) begin
                    last_resp_cyc = cyc;
                    if (i_resp_valid === 1'b1 && d_resp_valid === 1'b1) begin
                        nvec++; nfail++;
                        $display("FAIL resp_exclusive: got both resp_valid, required one");
                    end else if (exp_q.size() == 0) begin
                        nvec++; nfail++;
                        $display("FAIL unexpected_resp: got i=%b d=%b, required no pulse", i_resp_valid, d_resp_valid);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_owner_is_d", d_resp_valid, e.is_d);
                        chk("resp_data", d_resp_valid ? d_resp_data : i_resp_data, e.data);
                        if (e.lat > 0) chk("resp_latency", cyc - e.acc_cyc, e.lat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic is_d, input MemOp op, input logic [15:0] addr,
                         input logic [15:0] wdata, input int mdly, input logic [15:0] exp_data,
                         input int lat, output int acc);
        bit got;
        logic wr;
        got = 1'b0;
        acc = -1;
        wr = is_d && (op == MEM_WRITE);
        mem_delay = mdly;
        if (is_d) begin
            d_req_valid = 1'b1; d_req_addr = addr; d_req_op = op; d_req_wdata = wdata;
        end else begin
            i_req_valid = 1'b1; i_req_addr = addr;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            #1;
            if ((is_d ? d_req_ready : i_req_ready) === 1'b1) begin
                got = 1'b1;
                acc = cyc;
                exp_q.push_back('{is_d, exp_data, lat, cyc});
                mreq_q.push_back('{addr, wr, wr ? wdata : 16'h0000});
            end
            @(negedge clk);
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        i_req_addr = 16'h5555; d_req_addr = 16'h5555; d_req_wdata = 16'h5555;
        chk("accepted", got, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            nvec++; nfail++;
            $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        logic gseq[10];
        logic exp_d;
        int acc1, acc2, g, k;

        tbl[0] = '{1'b1, MEM_READ,  16'h0040, 16'h0000, 0, 16'hBEEF};
        tbl[1] = '{1'b1, MEM_WRITE, 16'h0010, 16'h1234, 3, 16'h0000};
        tbl[2] = '{1'b0, MEM_READ,  16'h0010, 16'h0000, 0, 16'h1234};
        tbl[3] = '{1'b0, MEM_READ,  16'h0222, 16'h0000, 1, 16'hC1E1};
        tbl[4] = '{1'b1, MEM_WRITE, 16'hFFFF, 16'hA5A5, 2, 16'h0000};
        tbl[5] = '{1'b1, MEM_READ,  16'hFFFF, 16'h0000, 0, 16'hA5A5};
        tbl[6] = '{1'b0, MEM_READ,  16'h0000, 16'h0000, 0, 16'hC3C3};

        // Reset with both requesters valid
        n_rst = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 16'h0100;
        d_req_valid = 1'b1; d_req_addr = 16'h0300; d_req_op = MEM_READ; d_req_wdata = 16'h0000;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            mon_en = 1'b1;
            chk("rst_i_ready", i_req_ready, 0);
            chk("rst_d_ready", d_req_ready, 0);
            chk("rst_mem_req_valid", mem_req_valid, 0);
            chk("rst_resp_valid", {i_resp_valid, d_resp_valid}, 0);
            chk("rst_resp_data", {i_resp_data, d_resp_data}, 0);
        end
        n_rst = 1'b1;
        mem_delay = 0;
        #1;
        chk("post_rst_d_ready", d_req_ready, 1);
        chk("post_rst_i_ready", i_req_ready, 0);
        if (d_req_ready === 1'b1) begin
            exp_q.push_back('{1'b1, 16'hC0C3, 3, cyc});
            mreq_q.push_back('{16'h0300, 1'b0, 16'h0000});
        end
        @(negedge clk);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        drain();

        // Single transactions from the table
        for (int v = 0; v < 7; v++) begin
            issue(tbl[v].is_d, tbl[v].op, tbl[v].addr, tbl[v].wdata, tbl[v].mdly,
                  tbl[v].exp, 3 + tbl[v].mdly, acc1);
            drain();
            chk("req_hold_cycles", last_hold, tbl[v].mdly + 1);
        end

        // Both requesters continuously valid
        mem_delay = 0;
        i_req_valid = 1'b1; i_req_addr = 16'h0100;
        d_req_valid = 1'b1; d_req_addr = 16'h0200; d_req_op = MEM_READ;
        g = 0; k = 0;
        while (g < 10 && k < 200) begin
            #1;
            if (d_req_ready === 1'b1 || i_req_ready === 1'b1) begin
                gseq[g] = d_req_ready;
                exp_q.push_back('{d_req_ready, (d_req_ready === 1'b1) ? 16'hC1C3 : 16'hC2C3, 3, cyc});
                mreq_q.push_back('{(d_req_ready === 1'b1) ? 16'h0200 : 16'h0100, 1'b0, 16'h0000});
                g++;
            end
            @(negedge clk);
            k++;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        chk("starve_grants", g, 10);
        drain();
        for (int n = 0; n < g; n++) begin
`ifdef MEM_PORT_ARB_RR_EN
            exp_d = (n % 2 == 0);
`else
            exp_d = (n % 5 != 4);
`endif
            chk("grant_order_is_d", gseq[n], exp_d);
        end

        // Back-to-back: next request accepted in the response cycle
        issue(1'b1, MEM_READ, 16'h0600, 16'h0000, 0, 16'hC5C3, 3, acc1);
        issue(1'b0, MEM_READ, 16'h0700, 16'h0000, 0, 16'hC4C3, 3, acc2);
        chk("b2b_accept_cycle", acc2, last_resp_cyc);
        drain();

        // Spurious memory response while idle
        #2 spur = 1'b1;
        @(negedge clk);
        #2 spur = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("spur_no_resp", {i_resp_valid, d_resp_valid}, 0);
        end

        // Reset while waiting for the memory response
        resp_delay = 2;
        issue(1'b1, MEM_READ, 16'h0800, 16'h0000, 0, 16'hCBC3, 0, acc1);
        @(negedge clk);
        chk("in_wait_mem_req_valid", mem_req_valid, 0);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        exp_q.delete();
        mreq_q.delete();
        resp_delay = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("abort_no_resp", {i_resp_valid, d_resp_valid}, 0);
            chk("abort_idle", mem_req_valid, 0);
        end
        issue(1'b1, MEM_READ, 16'h0040, 16'h0000, 0, 16'hBEEF, 3, acc1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
